// File: rtl/hardware_loader_pkg.sv
// rtl/hardware_loader_pkg.sv - shared types and constants for the program loader
package hardware_loader_pkg;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  // Word width shared with the reducer's result port.
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    START,
    RUN,
    ERR
  } state_e;

endpackage

// File: rtl/hardware_byte_packer.sv
// rtl/hardware_byte_packer.sv - packs an LSB-first byte stream into words
module hardware_byte_packer
  import hardware_loader_pkg::*;
#(
  parameter int BYTES = WORD_BYTES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic [8*BYTES-1:0]   word_o,
  output logic                 word_done_o
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  // Only the bytes still waiting for the final one are stored; the last byte
  // completes the word combinationally so the caller can register it directly.
  logic [8*(BYTES-1)-1:0] pack_q, pack_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  assign word_o      = {byte_data_i, pack_q};
  assign word_done_o = byte_valid_i && (idx_q == IDX_W'(BYTES - 1));

  always_comb begin
    pack_d = pack_q;
    idx_d  = idx_q;
    if (clear_i) begin
      pack_d = '0;
      idx_d  = '0;
    end else if (byte_valid_i) begin
      pack_d = word_o[8*BYTES-1:8];
      idx_d  = word_done_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pack_q <= '0;
      idx_q  <= '0;
    end else begin
      pack_q <= pack_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/hardware_program_loader.sv
// rtl/hardware_program_loader.sv - loads a length-prefixed program into heap RAM, then starts the core
module hardware_program_loader
  import hardware_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              start,
  output logic              busy,
  output logic              err,
  input  logic              halt_i
);

  localparam int          PACK_BYTES = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;
  localparam logic [32:0] MAX_WORDS  = 33'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W:0]     n_q, n_d;
  logic                in_ready_q, mem_we_q, mem_we_d, start_q, busy_q, err_q;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [WORD_W-1:0]   pack_word;
  logic                word_done, xfer, pack_clear;

  assign xfer       = in_valid && in_ready_q;
  assign pack_clear = (state_q == START) || (state_q == RUN) || (state_q == ERR);
  assign cnt_inc    = cnt_q + 1'b1;

  hardware_byte_packer #(
    .BYTES(PACK_BYTES)
  ) u_packer (
    .clk_i       (system1000),
    .rst_i       (system1000_rst),
    .clear_i     (pack_clear),
    .byte_valid_i(xfer),
    .byte_data_i (in_data),
    .word_o      (pack_word),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      HDR: if (word_done) begin
        cnt_d = '0;
        if (pack_word == '0) begin
          state_d = START;
        end else if ({1'b0, pack_word} > MAX_WORDS) begin
          state_d = ERR;
        end else begin
          state_d = LOAD;
          n_d     = pack_word[ADDR_W:0];
        end
      end
      LOAD: if (word_done) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = cnt_q[ADDR_W-1:0];
        mem_wdata_d = pack_word;
        cnt_d       = cnt_inc;
        if (cnt_inc == n_q) state_d = START;
      end
      START: state_d = RUN;
      // A halt coinciding with the start pulse belongs to the previous run.
      RUN: if (halt_i && !start_q) begin
        state_d = HDR;
        cnt_d   = '0;
        n_d     = '0;
      end
      ERR: state_d = ERR;
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q     <= HDR;
      cnt_q       <= '0;
      n_q         <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      in_ready_q  <= (state_d == HDR) || (state_d == LOAD);
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      start_q     <= (state_q == START);
      busy_q      <= (state_q == RUN) && (state_d == RUN);
      err_q       <= (state_d == ERR);
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_hardware_program_loader.sv
// tb/tb_hardware_program_loader.sv - scoreboard bench for the program loader
module tb_hardware_program_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          halt = 1'b0;
  logic          in_ready, mem_we, start, busy, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  hardware_program_loader #(.ADDR_W(AW)) dut (
    .system1000    (clk),
    .system1000_rst(rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .start         (start),
    .busy          (busy),
    .err           (err),
    .halt_i        (halt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int n_writes = 0;
  int last_we_cyc = 0;
  int last_byte_cyc = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_e;
  logic [31:0]    prog [0:15];

  always @(negedge clk) begin
    if (mem_we) begin
      n_writes++;
      last_we_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%0d data=%h required=none", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_e) begin
          fails++;
          $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                   mem_addr, mem_wdata, mon_e[AW+31:32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL byte_accept_timeout in_ready=%b required=1", in_ready);
    end
    last_byte_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_prog(input int n, input int gap);
    send_word(32'(n), gap);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({AW'(i), prog[i]});
      send_word(prog[i], gap);
    end
  endtask

  task automatic wait_start(output int c);
    c = -1;
    for (int k = 0; k < 40; k++) begin
      if (start) begin
        c = cyc;
        break;
      end
      @(negedge clk);
    end
    if (c < 0) begin
      tests++;
      fails++;
      $display("FAIL start_timeout start=%b required=1", start);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({in_ready, mem_we, start, busy, err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs {rdy,we,start,busy,err}=%b required=00000",
               {in_ready, mem_we, start, busy, err});
    end
    tests++;
    if ({mem_addr, mem_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_mem addr=%0d data=%h required 0/0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset in_ready=%b required=1", in_ready);
    end
  endtask

  task automatic test_two_words(input int gap);
    int w0, s;
    prog[0] = 32'h12345678;
    prog[1] = 32'hDEADBEEF;
    w0 = n_writes;
    send_prog(2, gap);
    wait_start(s);
    tests++;
    if (n_writes - w0 != 2) begin
      fails++;
      $display("FAIL two_words_count gap=%0d writes=%0d required=2", gap, n_writes - w0);
    end
    tests++;
    if (s - last_byte_cyc != 2) begin
      fails++;
      $display("FAIL start_after_byte gap=%0d delay=%0d required=2", gap, s - last_byte_cyc);
    end
    tests++;
    if (s - last_we_cyc != 1) begin
      fails++;
      $display("FAIL start_after_we gap=%0d delay=%0d required=1", gap, s - last_we_cyc);
    end
    @(negedge clk);
    tests++;
    if ({busy, in_ready, start} !== 3'b100) begin
      fails++;
      $display("FAIL run_state {busy,rdy,start}=%b required=100", {busy, in_ready, start});
    end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    tests++;
    if ({busy, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL halt_release {busy,rdy}=%b required=01", {busy, in_ready});
    end
  endtask

  task automatic test_zero_len;
    int w0, s, c;
    w0 = n_writes;
    send_word(32'h0, 0);
    c = last_byte_cyc;
    halt = 1'b1;
    wait_start(s);
    tests++;
    if (s - c != 2) begin
      fails++;
      $display("FAIL zero_start_delay delay=%0d required=2", s - c);
    end
    @(negedge clk);
    tests++;
    if ({busy, in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL halt_with_start {busy,rdy}=%b required=10", {busy, in_ready});
    end
    @(negedge clk);
    halt = 1'b0;
    tests++;
    if ({busy, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL zero_halt {busy,rdy}=%b required=01", {busy, in_ready});
    end
    tests++;
    if (n_writes != w0) begin
      fails++;
      $display("FAIL zero_no_write writes=%0d required=0", n_writes - w0);
    end
    prog[0] = 32'hCAFEF00D;
    send_prog(1, 0);
    wait_start(s);
    tests++;
    if (n_writes - w0 != 1) begin
      fails++;
      $display("FAIL second_prog writes=%0d required=1", n_writes - w0);
    end
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
  endtask

  task automatic test_err;
    int w0;
    w0 = n_writes;
    send_word(32'd17, 0);
    tests++;
    if ({err, in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL err_set {err,rdy}=%b required=10", {err, in_ready});
    end
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if ({err, in_ready, start, busy} !== 4'b1000 || n_writes != w0) begin
      fails++;
      $display("FAIL err_sticky {err,rdy,start,busy}=%b writes=%0d required=1000/0",
               {err, in_ready, start, busy}, n_writes - w0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_reset err=%b required=0", err);
    end
    @(negedge clk);
  endtask

  task automatic test_full;
    int w0, s;
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    w0 = n_writes;
    send_prog(16, 0);
    wait_start(s);
    tests++;
    if (n_writes - w0 != 16 || s - last_we_cyc != 1) begin
      fails++;
      $display("FAIL full_load writes=%0d start_delay=%0d required=16/1",
               n_writes - w0, s - last_we_cyc);
    end
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
  endtask

  task automatic test_reset_mid;
    int w0, s;
    prog[0] = 32'h0BADF00D;
    w0 = n_writes;
    send_word(32'd2, 0);
    exp_q.push_back({AW'(0), prog[0]});
    send_word(prog[0], 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({in_ready, mem_we, start, busy, err} !== 5'b0 || {mem_addr, mem_wdata} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs flags=%b addr=%0d data=%h required=0/0/0",
               {in_ready, mem_we, start, busy, err}, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (n_writes - w0 != 1) begin
      fails++;
      $display("FAIL mid_reset_writes writes=%0d required=1", n_writes - w0);
    end
    prog[0] = 32'h5A5AC3C3;
    send_prog(1, 0);
    wait_start(s);
    tests++;
    if (n_writes - w0 != 2) begin
      fails++;
      $display("FAIL fresh_prog writes=%0d required=2", n_writes - w0);
    end
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_two_words(0);
    test_two_words(1);
    test_zero_len();
    test_err();
    test_full();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_writes left=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hardware_program_loader.md
# hardware_program_loader

Byte-stream receiver that loads a combinator program into the reducer's heap RAM and then starts the reducer. It sits in front of the reduction core and is the input-side counterpart of the core's result port. That port produces a valid flag, a 32-bit result word and a halt flag. This block takes a length-prefixed little-endian byte stream, packs it into 32-bit heap words, and writes them at consecutive addresses from 0. It then pulses `start` and holds off new input until the core reports halt.

## Interface
Parameters:
- `ADDR_W`, 16, heap address width; maximum program length is 2^ADDR_W words.

Ports:
- `system1000`  in  1  clock.
- `system1000_rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  heap write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  heap write address.
- `mem_wdata`  out  32  heap write data.
- `start`  out  1  one-cycle pulse: program loaded, core may run.
- `busy`  out  1  program loaded and core running.
- `err`  out  1  header length exceeds 2^ADDR_W; sticky until reset.
- `halt_i`  in  1  core halt flag, i.e. the core's result-port halt bit.

## Operation
- Stream format: 4 header bytes giving the word count N (32-bit, LSB first), then 4·N payload bytes. Each payload word is LSB first.
- A byte transfers when `in_valid && in_ready`. Producer holds `in_data` stable while `in_valid && !in_ready`.
- States:
  - HDR: collect 4 header bytes. On the 4th byte:
    - N == 0 → START.
    - N > 2^ADDR_W → ERR.
    - Otherwise → LOAD, with word counter = 0.
  - LOAD: accept bytes into a 32-bit shift/pack register with a 2-bit byte index. On each 4th byte, register a write with `mem_addr` = word counter and `mem_wdata` = assembled word, then increment the word counter. After word N−1 → START.
  - START: `start` = 1 for exactly one cycle → RUN.
  - RUN: `busy` = 1, `in_ready` = 0. When `halt_i` = 1 → HDR, and header/byte/word counters clear.
  - ERR: `in_ready` = 0, `err` = 1, no writes. Exit only by reset.
- `in_ready` = 1 in HDR and LOAD only; it is registered from state. Back-to-back bytes are accepted at 1 byte/cycle.
- `mem_addr` and `mem_wdata` hold their last written values when `mem_we` = 0.
- Word counter width is ADDR_W+1 so that N = 2^ADDR_W is representable. Addresses use the low ADDR_W bits.
- `halt_i` is ignored outside RUN. A `halt_i` asserted in the same cycle as `start` is ignored; RUN is entered first.

## Timing
- Reset values: state HDR, `in_ready` 0 during reset and 1 from the first cycle after reset deasserts. `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `start` 0, `busy` 0, `err` 0. Pack register and all counters are 0.
- `mem_we` rises the cycle after the 4th byte of a word is accepted.
- `start` pulses the cycle after the final `mem_we`, or 2 cycles after the last header byte when N = 0.
- `busy` rises in the cycle after `start`. It falls the cycle after `halt_i` is sampled high in RUN, and `in_ready` rises in that same cycle.
- Reset mid-load: all state is discarded, no further `mem_we` is issued, and heap contents are not cleared.
- Stalls: gaps in `in_valid` pause packing with no loss. Byte index and counters persist across gaps.

## Structure
- Shared package `hardware_loader_pkg`:
  - state enum {HDR, LOAD, START, RUN, ERR};
  - constants HDR_BYTES = 4 and WORD_BYTES = 4;
  - the word-width constant 32, shared with the reducer's result port.
- One sub-module, `hardware_byte_packer`: accepts bytes plus a clear input, outputs a 32-bit word with a `word_done` pulse. It is reused for both header and payload packing.
- Main module holds the FSM, counters and the write register.

## Test plan
- Reset, then stream `02 00 00 00 | 78 56 34 12 | EF BE AD DE`, back-to-back → writes (0, 0x12345678) and (1, 0xDEADBEEF) on consecutive word boundaries. `start` fires 1 cycle after the second `mem_we`, then `busy` = 1 and `in_ready` = 0.
- Same stream with `in_valid` toggling every other cycle → identical writes, and `start` follows the last byte by 2 cycles.
- Header `00 00 00 00` → no `mem_we`, `start` 2 cycles after the 4th byte. Assert `halt_i` → `busy` drops and `in_ready` returns the next cycle. A second program then loads at address 0.
- ADDR_W=4, header `11 00 00 00` (N=17) → `err` = 1, `in_ready` = 0, no writes. Reset clears `err`.
- ADDR_W=4, N=16 → 16 writes at addresses 0..15, then `start`.
- Assert `system1000_rst` after 6 payload bytes → no further `mem_we`, all outputs at reset values. A fresh 1-word program then loads correctly.
